drw_rect_addrgen: RTL and testbench
===================================

DRW_RECT_ADDRGEN -- requirements
Module: drw_rect_addrgen

Interface
REQ-001 SHALL have parameter ADDR_W, default 29, meaning byte-address width.
REQ-002 SHALL have parameter CRD_W, default 11, meaning coordinate, size and frame-width width.
REQ-003 SHALL have parameter BPP_LOG2, default 2, meaning log2 of bytes per pixel.
REQ-004 SHALL have parameter MAXLEN, default 256, meaning maximum beats per burst (power of two, 1..256).
REQ-005 SHALL have parameter SPLIT_4K, default 1, meaning 1 = no burst crosses a 4 KiB address boundary.
REQ-006 ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-007 ARST  in  1  reset, asynchronous, active-high.
REQ-008 START  in  1  request a new rectangle; sampled only in IDLE.
REQ-009 BASE_ADDR  in  ADDR_W  frame base byte address.
REQ-010 FRAME_WIDTH  in  CRD_W  frame stride in pixels.
REQ-011 POSX, POSY  in  CRD_W each  rectangle origin in pixels.
REQ-012 SIZX, SIZY  in  CRD_W each  rectangle size in pixels.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  one-cycle pulse when a rectangle completes.
REQ-015 CMD_VALID  out  1  burst command valid.
REQ-016 CMD_READY  in  1  consumer accepts the command.
REQ-017 CMD_ADDR  out  ADDR_W  burst start byte address.
REQ-018 CMD_LEN  out  8  AXI AxLEN, equal to beats-1.
REQ-019 CMD_LINE_END  out  1  command is the final burst of a line.
REQ-020 CMD_LAST  out  1  command is the final burst of the rectangle.

Function
REQ-021 The block SHALL implement states IDLE, CALC, RUN and FIN.
REQ-022 IDLE SHALL go to CALC on START=1 and latch all geometry inputs; geometry changes after that SHALL have no effect.
REQ-023 CALC SHALL last one cycle and compute line address = BASE + ((POSY*FRAME_WIDTH + POSX) << BPP_LOG2), modulo 2^ADDR_W.
REQ-024 CALC SHALL go to FIN if SIZX==0 or SIZY==0 (no commands issued), and to RUN otherwise.
REQ-025 CMD_VALID SHALL first be high two cycles after the START sample edge.
REQ-026 In RUN, beats per burst SHALL be the minimum of: MAXLEN; pixels remaining in the line; and, when SPLIT_4K=1, pixels up to the next 4 KiB boundary.
REQ-027 While CMD_VALID=1 and CMD_READY=0, CMD_ADDR, CMD_LEN, CMD_LINE_END and CMD_LAST SHALL hold stable, and CMD_VALID SHALL stay high.
REQ-028 A handshake (CMD_VALID & CMD_READY) on a non-final burst of a line SHALL advance CMD_ADDR by beats<<BPP_LOG2.
REQ-029 A handshake on the final burst of a line SHALL set CMD_ADDR to the line start plus FRAME_WIDTH<<BPP_LOG2 and reset the horizontal count.
REQ-030 CMD_VALID SHALL remain high across back-to-back handshakes, giving one command per cycle when READY is held high.
REQ-031 A handshake with CMD_LAST=1 SHALL move RUN to FIN and drop CMD_VALID the next cycle.
REQ-032 FIN SHALL last one cycle, assert DONE and return to IDLE; a START sampled in that IDLE cycle SHALL be accepted.
REQ-033 START SHALL be ignored outside IDLE.
REQ-034 Internal counts SHALL be CRD_W+1 bits wide, with no overflow for SIZX/SIZY up to 2^CRD_W-1.
REQ-035 CMD_LEN SHALL never exceed MAXLEN-1.

Reset
REQ-036 On ARST=1, regardless of clock, the block SHALL enter IDLE and clear BUSY, DONE, CMD_VALID, CMD_LINE_END, CMD_LAST, CMD_ADDR and CMD_LEN to 0.
REQ-037 On ARST mid-rectangle, all progress SHALL be discarded, and no command or DONE SHALL appear until a new START after reset release.

Verification
REQ-038 Defaults, SPLIT_4K=0, BASE=0x0100_0000, FW=640, POS=(10,2), SIZE=(300,2), READY=1 -> exactly 4 commands:
  - 0x0100_1428/255
  - 0x0100_1828/43 LINE_END
  - 0x0100_1E28/255
  - 0x0100_2228/43 LINE_END LAST
  - then a single DONE pulse.
REQ-039 SPLIT_4K=1, BASE=0, FW=1024, POS=(1000,0), SIZE=(100,1) -> 2 commands:
  - 0xFA0/23
  - 0x1000/75 LINE_END LAST
REQ-040 SIZX=0, SIZY=5 -> no CMD_VALID; DONE pulses 2 cycles after the START sample; BUSY high for exactly 2 cycles.
REQ-041 Backpressure: hold READY=0 for 5 cycles while the first command of REQ-038 is valid -> VALID and all CMD fields stable throughout; the sequence is otherwise unchanged.
REQ-042 Assert ARST after the 2nd handshake of REQ-038 -> all outputs 0 immediately; no further commands or DONE; a new START then yields the full REQ-038 sequence.
REQ-043 START pulses while BUSY -> ignored, with command count and DONE count unaffected.

Source files
------------

// File: rtl/drw_rect_addrgen_if.sv
// Control, geometry and burst-command signals of the rectangle address generator.
// master = generator side, slave = requester / command consumer side.
interface drw_rect_addrgen_if #(
    parameter int ADDR_W = 29,
    parameter int CRD_W  = 11
);
    logic              START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [CRD_W-1:0]  FRAME_WIDTH;
    logic [CRD_W-1:0]  POSX;
    logic [CRD_W-1:0]  POSY;
    logic [CRD_W-1:0]  SIZX;
    logic [CRD_W-1:0]  SIZY;
    logic              BUSY;
    logic              DONE;
    logic              CMD_VALID;
    logic              CMD_READY;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [7:0]        CMD_LEN;
    logic              CMD_LINE_END;
    logic              CMD_LAST;

    modport master (
        input  START, BASE_ADDR, FRAME_WIDTH, POSX, POSY, SIZX, SIZY, CMD_READY,
        output BUSY, DONE, CMD_VALID, CMD_ADDR, CMD_LEN, CMD_LINE_END, CMD_LAST
    );

    modport slave (
        output START, BASE_ADDR, FRAME_WIDTH, POSX, POSY, SIZX, SIZY, CMD_READY,
        input  BUSY, DONE, CMD_VALID, CMD_ADDR, CMD_LEN, CMD_LINE_END, CMD_LAST
    );
endinterface

// File: rtl/drw_rect_addrgen.sv
// Splits a pixel rectangle of a frame into AXI-style burst commands, one per cycle under READY.
// First command two cycles after START; commands hold stable while CMD_READY is low.
module drw_rect_addrgen #(
    parameter int ADDR_W   = 29,
    parameter int CRD_W    = 11,
    parameter int BPP_LOG2 = 2,
    parameter int MAXLEN   = 256,
    parameter int SPLIT_4K = 1
) (
    input  logic               ACLK,
    input  logic               ARST,
    drw_rect_addrgen_if.master bus
);
    localparam int CW = CRD_W + 1;
    localparam int MW = (CW > 14) ? CW : 14;
    localparam int PW = 2 * CRD_W + 1;

    typedef enum logic [1:0] {IDLE, CALC, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q, line_start, cur_addr;
    logic [CRD_W-1:0]  fw_q, posx_q, posy_q, sizx_q, sizy_q;
    logic [CW-1:0]     x_rem, y_rem;

    logic [PW-1:0]     pix_off;
    logic [ADDR_W-1:0] line_addr, next_line;
    logic [MW-1:0]     to_4k, beats;
    logic              in_run, hs, line_end, last;

    assign pix_off   = PW'(posy_q) * PW'(fw_q) + PW'(posx_q);
    assign line_addr = base_q + (ADDR_W'(pix_off) << BPP_LOG2);
    assign next_line = line_start + (ADDR_W'(fw_q) << BPP_LOG2);
    assign in_run    = (state == RUN);
    assign hs        = in_run & bus.CMD_READY;

    // A pixel straddling the page boundary still needs a one-beat burst, hence the floor of 1.
    always_comb begin
        to_4k = MW'((13'h1000 - {1'b0, cur_addr[11:0]}) >> BPP_LOG2);
        if (to_4k == '0)
            to_4k = MW'(1);
        beats = MW'(MAXLEN);
        if (MW'(x_rem) < beats)
            beats = MW'(x_rem);
        if (SPLIT_4K != 0 && to_4k < beats)
            beats = to_4k;
    end

    assign line_end = (beats == MW'(x_rem));
    assign last     = line_end && (y_rem == CW'(1));

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.START) state_nxt = CALC;
            CALC: state_nxt = (sizx_q == '0 || sizy_q == '0) ? FIN : RUN;
            RUN:  if (hs && last) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY         = (state != IDLE);
        bus.DONE         = (state == FIN);
        bus.CMD_VALID    = in_run;
        bus.CMD_ADDR     = '0;
        bus.CMD_LEN      = '0;
        bus.CMD_LINE_END = 1'b0;
        bus.CMD_LAST     = 1'b0;
        if (in_run) begin
            bus.CMD_ADDR     = cur_addr;
            bus.CMD_LEN      = 8'(beats - MW'(1));
            bus.CMD_LINE_END = line_end;
            bus.CMD_LAST     = last;
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            base_q     <= '0;
            fw_q       <= '0;
            posx_q     <= '0;
            posy_q     <= '0;
            sizx_q     <= '0;
            sizy_q     <= '0;
            line_start <= '0;
            cur_addr   <= '0;
            x_rem      <= '0;
            y_rem      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.START) begin
                    base_q <= bus.BASE_ADDR;
                    fw_q   <= bus.FRAME_WIDTH;
                    posx_q <= bus.POSX;
                    posy_q <= bus.POSY;
                    sizx_q <= bus.SIZX;
                    sizy_q <= bus.SIZY;
                end
                CALC: begin
                    line_start <= line_addr;
                    cur_addr   <= line_addr;
                    x_rem      <= CW'(sizx_q);
                    y_rem      <= CW'(sizy_q);
                end
                RUN: if (hs) begin
                    // Line wrap restarts from the saved line origin, not the running address.
                    if (line_end) begin
                        line_start <= next_line;
                        cur_addr   <= next_line;
                        x_rem      <= CW'(sizx_q);
                        y_rem      <= y_rem - CW'(1);
                    end else begin
                        cur_addr <= cur_addr + (ADDR_W'(beats) << BPP_LOG2);
                        x_rem    <= x_rem - CW'(beats);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_drw_rect_addrgen.sv
// Self-checking bench: rectangle vector table with a command scoreboard, plus
// hand sequences for zero-size, backpressure, mid-rectangle reset and START while busy.
module tb_drw_rect_addrgen;
    typedef struct packed {
        logic [28:0] addr;
        logic [7:0]  len;
        logic        le;
        logic        last;
    } cmd_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic valid;
        cmd_t cmd;
    } obs_t;

    typedef struct {
        bit          split;
        logic [28:0] base;
        logic [10:0] fw, px, py, sx, sy;
        int          first;
        int          n;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, rdy = 1'b1;
    logic [28:0] g_base = '0;
    logic [10:0] g_fw = '0, g_px = '0, g_py = '0, g_sx = '0, g_sy = '0;

    int   tests = 0;
    int   fails = 0;
    cmd_t exp_q[$];
    vec_t vecs[9];
    cmd_t cmds[15];
    int   r_nbusy, r_ndone, r_first_valid, r_done_cyc, r_hs_first, r_hs_last, r_nhs, r_oth;

    always #5 clk = ~clk;

    drw_rect_addrgen_if #(.ADDR_W(29), .CRD_W(11)) ifa ();
    drw_rect_addrgen_if #(.ADDR_W(29), .CRD_W(11)) ifb ();

    assign ifa.START = start_a;  assign ifb.START = start_b;
    assign ifa.BASE_ADDR = g_base;  assign ifb.BASE_ADDR = g_base;
    assign ifa.FRAME_WIDTH = g_fw;  assign ifb.FRAME_WIDTH = g_fw;
    assign ifa.POSX = g_px;  assign ifb.POSX = g_px;
    assign ifa.POSY = g_py;  assign ifb.POSY = g_py;
    assign ifa.SIZX = g_sx;  assign ifb.SIZX = g_sx;
    assign ifa.SIZY = g_sy;  assign ifb.SIZY = g_sy;
    assign ifa.CMD_READY = rdy;  assign ifb.CMD_READY = rdy;

    drw_rect_addrgen #(.SPLIT_4K(0)) dut_a (.ACLK(clk), .ARST(arst), .bus(ifa.master));
    drw_rect_addrgen #(.SPLIT_4K(1)) dut_b (.ACLK(clk), .ARST(arst), .bus(ifb.master));

    function automatic obs_t sample(input bit sel);
        obs_t o;
        if (sel)
            o = '{ifb.BUSY, ifb.DONE, ifb.CMD_VALID,
                  '{ifb.CMD_ADDR, ifb.CMD_LEN, ifb.CMD_LINE_END, ifb.CMD_LAST}};
        else
            o = '{ifa.BUSY, ifa.DONE, ifa.CMD_VALID,
                  '{ifa.CMD_ADDR, ifa.CMD_LEN, ifa.CMD_LINE_END, ifa.CMD_LAST}};
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rect(input vec_t v);
        g_base = v.base; g_fw = v.fw; g_px = v.px; g_py = v.py; g_sx = v.sx; g_sy = v.sy;
        for (int i = 0; i < v.n; i++)
            exp_q.push_back(cmds[v.first + i]);
        if (v.split) start_b = 1'b1; else start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_accept", 64'(sample(v.split).busy), 64'd1);
    endtask

    // Runs until the selected DUT returns to IDLE (or max_hs handshakes), scoring each command.
    task automatic drain(input bit sel, input int stall_n, input int max_hs, input bit poke);
        obs_t o, oth;
        cmd_t snap, e;
        bit   snapped;
        int   c;
        r_nbusy = 0; r_ndone = 0; r_nhs = 0; r_oth = 0;
        r_first_valid = -1; r_done_cyc = -1; r_hs_first = -1; r_hs_last = -1;
        snapped = 1'b0;
        snap = '0;
        c = 0;
        forever begin
            if (c >= 2000) begin
                tests++; fails++;
                $display("FAIL drain_timeout: got busy after %0d cycles, required idle", c);
                break;
            end
            o   = sample(sel);
            oth = sample(!sel);
            if (c == 0) begin
                g_base = 29'($urandom); g_fw = 11'($urandom); g_px = 11'($urandom);
                g_py = 11'($urandom); g_sx = 11'($urandom); g_sy = 11'($urandom);
            end
            if (oth.valid || oth.done) r_oth++;
            if (c > 0 && !o.busy) break;
            if (o.busy) r_nbusy++;
            if (o.done) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = c + 1;
            end
            if (o.valid && r_first_valid < 0) r_first_valid = c + 1;
            if (poke) begin
                if (sel) start_b = o.busy; else start_a = o.busy;
            end
            rdy = 1'b1;
            if (stall_n > 0 && (o.valid || snapped)) begin
                rdy = 1'b0;
                if (!snapped) begin
                    snap = o.cmd;
                    snapped = 1'b1;
                end else begin
                    chk("stall_valid", 64'(o.valid), 64'd1);
                    chk("stall_cmd", 64'(o.cmd), 64'(snap));
                end
                stall_n--;
            end
            if (o.valid && rdy) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_cmd: got addr %h len %0d, required no command",
                             o.cmd.addr, o.cmd.len);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("cmd%0d", r_nhs), 64'(o.cmd), 64'(e));
                end
                r_nhs++;
                if (r_hs_first < 0) r_hs_first = c + 1;
                r_hs_last = c + 1;
            end
            cycle();
            c++;
            if (max_hs > 0 && r_nhs >= max_hs) break;
        end
        rdy = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_vec(input int idx, input int stall_n, input bit poke);
        apply_rect(vecs[idx]);
        drain(vecs[idx].split, stall_n, 0, poke);
        chk($sformatf("v%0d_ncmd", idx), 64'(r_nhs), 64'(vecs[idx].n));
        chk($sformatf("v%0d_left", idx), 64'(exp_q.size()), 64'd0);
        chk($sformatf("v%0d_done", idx), 64'(r_ndone), 64'd1);
        chk($sformatf("v%0d_other", idx), 64'(r_oth), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        int nv, nd;
        vecs[0] = '{split:1'b0, base:29'h1000000, fw:11'd640, px:11'd10, py:11'd2, sx:11'd300, sy:11'd2, first:0, n:4};
        vecs[1] = '{split:1'b1, base:29'h0, fw:11'd1024, px:11'd1000, py:11'd0, sx:11'd100, sy:11'd1, first:4, n:2};
        vecs[2] = '{split:1'b1, base:29'h1000000, fw:11'd640, px:11'd10, py:11'd2, sx:11'd300, sy:11'd2, first:6, n:4};
        vecs[3] = '{split:1'b0, base:29'h10, fw:11'd8, px:11'd3, py:11'd1, sx:11'd1, sy:11'd1, first:10, n:1};
        vecs[4] = '{split:1'b0, base:29'h1000000, fw:11'd640, px:11'd10, py:11'd2, sx:11'd0, sy:11'd5, first:0, n:0};
        vecs[5] = '{split:1'b0, base:29'h1000000, fw:11'd640, px:11'd10, py:11'd2, sx:11'd5, sy:11'd0, first:0, n:0};
        vecs[6] = '{split:1'b0, base:29'h1FFFFFF0, fw:11'd4, px:11'd8, py:11'd0, sx:11'd2, sy:11'd1, first:11, n:1};
        vecs[7] = '{split:1'b0, base:29'h0, fw:11'd2047, px:11'd0, py:11'd0, sx:11'd257, sy:11'd1, first:12, n:2};
        vecs[8] = '{split:1'b0, base:29'h0, fw:11'd2047, px:11'd2047, py:11'd2047, sx:11'd1, sy:11'd1, first:14, n:1};
        cmds[0]  = '{29'h1001428, 8'd255, 1'b0, 1'b0};
        cmds[1]  = '{29'h1001828, 8'd43,  1'b1, 1'b0};
        cmds[2]  = '{29'h1001E28, 8'd255, 1'b0, 1'b0};
        cmds[3]  = '{29'h1002228, 8'd43,  1'b1, 1'b1};
        cmds[4]  = '{29'h0000FA0, 8'd23,  1'b0, 1'b0};
        cmds[5]  = '{29'h0001000, 8'd75,  1'b1, 1'b1};
        cmds[6]  = '{29'h1001428, 8'd255, 1'b0, 1'b0};
        cmds[7]  = '{29'h1001828, 8'd43,  1'b1, 1'b0};
        cmds[8]  = '{29'h1001E28, 8'd117, 1'b0, 1'b0};
        cmds[9]  = '{29'h1002000, 8'd181, 1'b1, 1'b1};
        cmds[10] = '{29'h000003C, 8'd0,   1'b1, 1'b1};
        cmds[11] = '{29'h0000010, 8'd1,   1'b1, 1'b1};
        cmds[12] = '{29'h0000000, 8'd255, 1'b0, 1'b0};
        cmds[13] = '{29'h0000400, 8'd0,   1'b1, 1'b1};
        cmds[14] = '{29'h0FFE000, 8'd0,   1'b1, 1'b1};

        repeat (2) cycle();
        chk("reset_a", 64'(sample(1'b0)), 64'd0);
        chk("reset_b", 64'(sample(1'b1)), 64'd0);
        arst = 1'b0;
        cycle();

        run_vec(0, 0, 1'b0);
        chk("valid_latency", 64'(r_first_valid), 64'd2);
        chk("b2b_span", 64'(r_hs_last - r_hs_first), 64'd3);
        for (int i = 1; i < 9; i++)
            run_vec(i, 0, 1'b0);

        run_vec(4, 0, 1'b0);
        chk("zero_busy_cycles", 64'(r_nbusy), 64'd2);
        chk("zero_done_cycle", 64'(r_done_cyc), 64'd2);
        chk("zero_no_valid", 64'(r_first_valid), 64'hFFFF_FFFF_FFFF_FFFF);

        run_vec(0, 5, 1'b0);
        chk("stall_hs_cycle", 64'(r_hs_first), 64'd7);

        run_vec(0, 0, 1'b1);

        apply_rect(vecs[0]);
        drain(1'b0, 0, 2, 1'b0);
        arst = 1'b1;
        #1;
        chk("arst_async", 64'(sample(1'b0)), 64'd0);
        cycle();
        cycle();
        arst = 1'b0;
        exp_q.delete();
        nv = 0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ifa.CMD_VALID) nv++;
            if (ifa.DONE || ifa.BUSY) nd++;
        end
        chk("post_rst_valid", 64'(nv), 64'd0);
        chk("post_rst_activity", 64'(nd), 64'd0);
        run_vec(0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
